// File: rtl/move_cmd_uart_tx.sv
// ---------------------------------------------------------------------------
// move_cmd_uart_tx
//   Receives drive commands from the line-following controller. Each new
//   command is framed as a 4-byte packet and sent over an 8N1 UART to the
//   robot base. The packet is {SYNC_BYTE, cmd, speed, xor-checksum}.
//   Repeated identical commands are ignored. While a packet is on the line,
//   one more command can wait in a pending slot; a newer command replaces it.
//   When no new command arrives for KEEPALIVE_CYCLES after a packet start,
//   the last command is sent again so that the base does not time out.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   cmd_valid    1-cycle strobe qualifying move_cmd / speed_level
//   move_cmd     4-bit drive code (W/WA/WD/A/D/STOP); illegal codes mean STOP
//   speed_level  4-bit speed, 0..15
//   tx           UART serial output, idle high
//   busy         high while a packet is in flight
//   pkt_sent     1-cycle pulse as the final stop bit ends on the line
//   cmd_dropped  1-cycle pulse when a pending command is overwritten
// ---------------------------------------------------------------------------
module move_cmd_uart_tx #(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned BAUD             = 115_200,
  parameter int unsigned KEEPALIVE_CYCLES = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE        = 8'hAA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] move_cmd,
  input  logic [3:0] speed_level,
  output logic       tx,
  output logic       busy,
  output logic       pkt_sent,
  output logic       cmd_dropped
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned KA_W   = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [KA_W-1:0]   KA_LAST   = KA_W'(KEEPALIVE_CYCLES - 1);

  // Command word layout: {move_cmd[3:0], speed[3:0]}
  localparam logic [7:0] CMD_STOP0 = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Registers
  state_e            state_q,      state_d;
  logic [BAUD_W-1:0] baud_q,       baud_d;
  logic [2:0]        bit_q,        bit_d;
  logic [1:0]        byte_q,       byte_d;
  logic [7:0]        pkt_q,        pkt_d;
  logic [7:0]        pend_q,       pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        last_q,       last_d;
  logic [KA_W-1:0]   ka_q,         ka_d;
  logic              tx_q,         tx_d;
  logic              busy_q,       busy_d;
  logic              fin_q,        fin_d;
  logic              pkt_sent_q,   pkt_sent_d;
  logic              dropped_q,    dropped_d;

  // Datapath helpers
  logic [7:0] san_cmd;
  logic [7:0] cur_byte;
  logic       accept;
  logic       cap_pend;
  logic       cap_ka;
  logic       capture;
  logic       baud_done;

  // Illegal move codes collapse to STOP at speed 0.
  always_comb begin
    san_cmd = CMD_STOP0;
    unique case (move_cmd)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101, 4'b1000: san_cmd = {move_cmd, speed_level};
      default:                   san_cmd = CMD_STOP0;
    endcase
  end

  always_comb begin
    cur_byte = SYNC_BYTE;
    unique case (byte_q)
      2'd0: cur_byte = SYNC_BYTE;
      2'd1: cur_byte = {4'h0, pkt_q[7:4]};
      2'd2: cur_byte = {4'h0, pkt_q[3:0]};
      2'd3: cur_byte = SYNC_BYTE ^ {4'h0, pkt_q[7:4]} ^ {4'h0, pkt_q[3:0]};
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign accept    = cmd_valid && (san_cmd != last_q);
  assign cap_pend  = (state_q == S_IDLE) && pend_valid_q;
  // Keepalive only fires with an empty slot; a pending send takes priority.
  assign cap_ka    = (state_q == S_IDLE) && !pend_valid_q && (ka_q == KA_LAST);
  assign capture   = cap_pend || cap_ka;
  assign baud_done = (baud_q == BAUD_LAST);

  // Serialiser FSM. tx is registered from tx_d, so the line trails the
  // state by one cycle: the capture edge is followed by the start bit edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pkt_d   = pkt_q;
    tx_d    = 1'b1;
    fin_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (capture) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          pkt_d   = pend_valid_q ? pend_q : last_q;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Command intake, pending slot, keepalive and status outputs.
  // fin_q delays completion by one cycle so pkt_sent/busy line up with the
  // end of the stop bit on tx, while the FSM is already free to capture.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    last_d       = last_q;
    dropped_d    = 1'b0;
    busy_d       = busy_q;
    pkt_sent_d   = fin_q;

    if (cap_pend) begin
      pend_valid_d = 1'b0;
    end
    if (accept) begin
      pend_d       = san_cmd;
      pend_valid_d = 1'b1;
      last_d       = san_cmd;
      dropped_d    = pend_valid_q && !cap_pend;
    end

    if (capture) begin
      ka_d = '0;
    end else if (ka_q == KA_LAST) begin
      ka_d = ka_q;
    end else begin
      ka_d = ka_q + 1'b1;
    end

    if (capture) begin
      busy_d = 1'b1;
    end else if (fin_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      pkt_q        <= CMD_STOP0;
      pend_q       <= CMD_STOP0;
      pend_valid_q <= 1'b0;
      last_q       <= CMD_STOP0;
      ka_q         <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      pkt_sent_q   <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      pkt_q        <= pkt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      last_q       <= last_d;
      ka_q         <= ka_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      fin_q        <= fin_d;
      pkt_sent_q   <= pkt_sent_d;
      dropped_q    <= dropped_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign pkt_sent    = pkt_sent_q;
  assign cmd_dropped = dropped_q;

endmodule
